// File: rtl/acq_readout_seq.sv
// Readout sequencer for a show-ahead ADC FIFO. Each trigger reads SKIP+POINTS words.
// It counts measurements within a frame, and flags overrun and FIFO starvation.
module acq_readout_seq #(
  parameter int POINTS   = 10,
  parameter int SKIP     = 5,
  parameter int MEASURES = 100,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  input  logic        fifo_empty,
  input  logic        clr_err,
  output logic        rdreq,
  output logic [10:0] cnt_point,
  output logic [16:0] cnt_measure,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout
);

  localparam int TOTAL   = SKIP + POINTS;
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [10:0]        LAST_POINT   = 11'(TOTAL - 1);
  localparam logic [16:0]        LAST_MEASURE = 17'(MEASURES - 1);
  localparam logic [STALL_W-1:0] LAST_STALL   = STALL_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, READ} state_t;

  state_t             state;
  logic [STALL_W-1:0] stall_cnt;

  // Show-ahead FIFO: q is already valid, so the strobe can be combinational
  assign rdreq = (state == READ) && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt_point   <= '0;
      cnt_measure <= '0;
      stall_cnt   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Clear first so that a coincident set below takes priority
      if (clr_err) begin
        overrun <= 1'b0;
        timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (trigger) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (trigger) overrun <= 1'b1;
          if (!fifo_empty) begin
            stall_cnt <= '0;
            if (cnt_point == LAST_POINT) begin
              cnt_point <= '0;
              state     <= IDLE;
              busy      <= 1'b0;
              if (cnt_measure == LAST_MEASURE) begin
                cnt_measure <= '0;
                frame_done  <= 1'b1;
              end else begin
                cnt_measure <= cnt_measure + 17'd1;
              end
            end else begin
              cnt_point <= cnt_point + 11'd1;
            end
          end else if (stall_cnt == LAST_STALL) begin
            // Starved too long: abandon this measurement, keep the frame position
            stall_cnt <= '0;
            cnt_point <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
            timeout   <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_readout_seq.sv
// Bench for acq_readout_seq: per-cycle comparison against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_acq_readout_seq;

  localparam int POINTS   = 10;
  localparam int SKIP     = 5;
  localparam int MEASURES = 100;
  localparam int TIMEOUT  = 16;
  localparam int TOTAL    = SKIP + POINTS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger = 1'b0;
  logic        fifo_empty = 1'b0;
  logic        clr_err = 1'b0;
  logic        rdreq;
  logic [10:0] cnt_point;
  logic [16:0] cnt_measure;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  acq_readout_seq #(
    .POINTS(POINTS), .SKIP(SKIP), .MEASURES(MEASURES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .fifo_empty(fifo_empty),
    .clr_err(clr_err), .rdreq(rdreq), .cnt_point(cnt_point),
    .cnt_measure(cnt_measure), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a measurement is "reading" until TOTAL words have been taken
  bit m_read, m_fd, m_ovr, m_to;
  int m_pt, m_meas, m_stall;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_read = 0; m_fd = 0; m_ovr = 0; m_to = 0;
      m_pt = 0; m_meas = 0; m_stall = 0;
    end else begin
      m_fd = 0;
      if (clr_err) begin
        m_ovr = 0;
        m_to  = 0;
      end
      if (!m_read) begin
        if (trigger) m_read = 1;
      end else begin
        if (trigger) m_ovr = 1;
        if (!fifo_empty) begin
          m_stall = 0;
          if (m_pt == TOTAL - 1) begin
            m_pt   = 0;
            m_read = 0;
            m_meas = (m_meas + 1) % MEASURES;
            m_fd   = (m_meas == 0);
          end else begin
            m_pt++;
          end
        end else begin
          m_stall++;
          if (m_stall == TIMEOUT) begin
            m_stall = 0;
            m_pt    = 0;
            m_read  = 0;
            m_to    = 1;
          end
        end
      end
    end
  end

  // Per-cycle compare plus read/frame bookkeeping
  int rd_cnt = 0;
  int fd_cnt = 0;
  int fd_at  = 0;
  int pts_log [64];

  always @(negedge clk) begin
    chk("rdreq", rdreq, m_read && !fifo_empty && !rst);
    chk("cnt_point", cnt_point, m_pt);
    chk("cnt_measure", cnt_measure, m_meas);
    chk("busy", busy, m_read);
    chk("frame_done", frame_done, m_fd);
    chk("overrun", overrun, m_ovr);
    chk("timeout", timeout, m_to);
    if (rdreq) begin
      pts_log[rd_cnt % 64] = int'(cnt_point);
      rd_cnt++;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_at = rd_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: busy still %0d expected 0 after 200 cycles", busy);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  int base, fdb;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rdreq", rdreq, 0);
    chk("rst_cnt_point", cnt_point, 0);
    chk("rst_cnt_measure", cnt_measure, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {frame_done, overrun, timeout}, 0);
    rst = 1'b0;
    tick();

    // Single measurement, FIFO never empty
    base = rd_cnt;
    start();
    chk("s1_busy_rise", busy, 1);
    wait_idle();
    chk("s1_reads", rd_cnt - base, 15);
    chk("s1_first_pt", pts_log[base % 64], 0);
    chk("s1_last_pt", pts_log[(base + 14) % 64], 14);
    chk("s1_measure", cnt_measure, 1);
    chk("s1_busy", busy, 0);

    // Three-cycle stall after read index 7
    base = rd_cnt;
    start();
    repeat (8) tick();
    fifo_empty = 1'b1;
    #1;
    chk("s2_rdreq_stall", rdreq, 0);
    chk("s2_pt_hold", cnt_point, 8);
    repeat (3) tick();
    chk("s2_pt_hold_end", cnt_point, 8);
    fifo_empty = 1'b0;
    wait_idle();
    chk("s2_reads", rd_cnt - base, 15);
    chk("s2_timeout", timeout, 0);
    chk("s2_measure", cnt_measure, 2);

    // Trigger during reads at index 5
    base = rd_cnt;
    start();
    repeat (5) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("s3_overrun", overrun, 1);
    chk("s3_pt", cnt_point, 6);
    wait_idle();
    chk("s3_reads", rd_cnt - base, 15);
    chk("s3_measure", cnt_measure, 3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s3_clr", overrun, 0);

    // Trigger on the same edge as the final read
    start();
    repeat (14) tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    chk("s3b_busy", busy, 0);
    chk("s3b_overrun", overrun, 1);
    chk("s3b_measure", cnt_measure, 4);
    tick();
    chk("s3b_no_restart", busy, 0);

    // Set and clear on the same edge: set wins
    start();
    repeat (3) tick();
    trigger = 1'b1;
    clr_err = 1'b1;
    tick();
    trigger = 1'b0;
    clr_err = 1'b0;
    chk("s3c_set_wins", overrun, 1);
    wait_idle();
    chk("s3c_measure", cnt_measure, 5);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s3c_clr", overrun, 0);

    // Starvation after read index 3
    start();
    repeat (4) tick();
    fifo_empty = 1'b1;
    repeat (15) tick();
    chk("s4_timeout_early", timeout, 0);
    chk("s4_busy_early", busy, 1);
    chk("s4_pt_hold", cnt_point, 4);
    tick();
    chk("s4_timeout", timeout, 1);
    chk("s4_idle", busy, 0);
    chk("s4_pt", cnt_point, 0);
    chk("s4_measure", cnt_measure, 5);
    fifo_empty = 1'b0;
    tick();
    chk("s4_stay_idle", busy, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s4_clr", timeout, 0);

    // Reset in the middle of a measurement
    start();
    repeat (9) tick();
    chk("s5_pre_pt", cnt_point, 9);
    rst = 1'b1;
    #1;
    chk("s5_rdreq", rdreq, 0);
    chk("s5_pt", cnt_point, 0);
    chk("s5_measure", cnt_measure, 0);
    chk("s5_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    start();
    chk("s5_restart_pt", cnt_point, 0);
    chk("s5_restart_measure", cnt_measure, 0);
    chk("s5_restart_rdreq", rdreq, 1);
    wait_idle();
    chk("s5_measure_after", cnt_measure, 1);

    // Full frame of 100 measurements
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    base = rd_cnt;
    fdb  = fd_cnt;
    for (int i = 0; i < MEASURES - 1; i++) begin
      start();
      wait_idle();
    end
    chk("s6_measure_99", cnt_measure, 99);
    chk("s6_no_early_fd", fd_cnt - fdb, 0);
    start();
    wait_idle();
    chk("s6_wrap", cnt_measure, 0);
    chk("s6_fd_now", frame_done, 1);
    tick();
    chk("s6_fd_pulse", frame_done, 0);
    chk("s6_fd_count", fd_cnt - fdb, 1);
    chk("s6_fd_after_reads", fd_at - base, 1500);
    chk("s6_reads", rd_cnt - base, 1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acq_readout_seq.md
ACQ_READOUT_SEQ -- requirements
Module: acq_readout_seq

Interface
REQ-001 SHALL provide parameter POINTS, default 10: accumulated points per measurement.
REQ-002 SHALL provide parameter SKIP, default 5: leading FIFO words per measurement read and discarded by the accumulator.
REQ-003 SHALL provide parameter MEASURES, default 100: measurements per frame.
REQ-004 SHALL provide parameter TIMEOUT, default 1024: maximum consecutive empty-FIFO cycles tolerated mid-measurement.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port trigger, input, 1 bit: level sampled each clk; high in IDLE starts one measurement.
REQ-008 SHALL have port fifo_empty, input, 1 bit: high when the show-ahead ADC FIFO holds no word.
REQ-009 SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-010 SHALL have port rdreq, output, 1 bit: FIFO read strobe; FIFO q is valid in the same cycle.
REQ-011 SHALL have port cnt_point, output, 11 bits: index of the word being read while rdreq is high.
REQ-012 SHALL have port cnt_measure, output, 17 bits: index of the current measurement within the frame.
REQ-013 SHALL have port busy, output, 1 bit: high while in READ.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-015 SHALL have port overrun, output, 1 bit: sticky; trigger seen while busy.
REQ-016 SHALL have port timeout, output, 1 bit: sticky; measurement aborted on FIFO starvation.

Function
REQ-017 SHALL implement the states IDLE and READ; TOTAL = SKIP+POINTS words per measurement.
REQ-018 SHALL move IDLE->READ on the clk edge where trigger=1; busy rises in the next cycle.
REQ-019 SHALL drive rdreq combinationally as (state==READ) and !fifo_empty; rdreq SHALL be 0 in IDLE.
REQ-020 SHALL increment cnt_point by 1 on every edge where rdreq=1, except the last read.
REQ-021 SHALL, on the edge where rdreq=1 and cnt_point==TOTAL-1: set cnt_point to 0, advance cnt_measure, and return to IDLE.
REQ-022 SHALL advance cnt_measure by 1, wrapping MEASURES-1 -> 0; on the wrap, frame_done SHALL be 1 for exactly the following cycle.
REQ-023 SHALL, when fifo_empty stalls READ, hold cnt_point and count stall cycles; the stall counter SHALL reset on any read.
REQ-024 SHALL, when the stall count reaches TIMEOUT: go to IDLE, set timeout, clear cnt_point to 0, and leave cnt_measure unchanged.
REQ-025 SHALL, for trigger=1 in READ, ignore the trigger and set overrun; a trigger on the same edge as the final read also sets overrun.
REQ-026 SHALL clear overrun and timeout on clr_err=1; if a set condition and clr_err coincide, set SHALL win.
REQ-027 SHALL require counter widths of at least 11 bits for TOTAL and 17 bits for MEASURES; the stall counter SHALL be wide enough for TIMEOUT.

Reset
REQ-028 SHALL, while rst=1 (asynchronously): force state=IDLE, cnt_point=0, cnt_measure=0, busy=0, frame_done=0, overrun=0, timeout=0, stall counter=0.
REQ-029 SHALL drive rdreq=0 during reset regardless of fifo_empty.
REQ-030 SHALL abort an in-progress measurement on mid-READ reset; the first trigger after release SHALL start at cnt_point=0, cnt_measure=0.

Verification
REQ-031 SHALL cover: fifo_empty=0, one trigger pulse -> rdreq high 15 consecutive cycles; cnt_point 0..14; then cnt_measure=1, busy=0.
REQ-032 SHALL cover: 100 triggers, FIFO never empty -> cnt_measure 99->0 and frame_done high exactly one cycle after the 1500th read.
REQ-033 SHALL cover: fifo_empty=1 for 3 cycles after read index 7 -> rdreq low 3 cycles; cnt_point holds 8; 15 reads total; timeout stays 0.
REQ-034 SHALL cover: TIMEOUT=16, fifo_empty held high after read index 3 -> timeout=1 after 16 stall cycles; state IDLE; cnt_point=0; cnt_measure unchanged.
REQ-035 SHALL cover: trigger at read index 5 -> overrun=1, read sequence unaffected; clr_err pulse -> overrun=0.
REQ-036 SHALL cover: rst asserted at read index 9 -> all outputs 0 immediately; next trigger -> reads restart at cnt_point=0, cnt_measure=0.
